// File: rtl/csr_trap_ctrl.sv
// Execute-stage sequencer in front of the 8-entry CSR file: CSR read-modify-write,
// ECALL/MRET handling, rd write-back and a valid/ready PC redirect to fetch.
module csr_trap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [11:0]           in_csr,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic                  in_rs1_zero,
  input  logic [RD_WIDTH-1:0]   in_rd,
  input  logic [31:0]           in_pc,
  output logic [2:0]            csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [2:0]            csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_wen,
  output logic                  csr_ecall,
  output logic [31:0]           csr_pc,
  output logic                  wb_valid,
  output logic [RD_WIDTH-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  redir_valid,
  input  logic                  redir_ready,
  output logic [31:0]           redir_pc,
  output logic                  illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2,
    REDIR = 2'd3
  } state_t;

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  function automatic logic [2:0] csr_index(input logic [11:0] num);
    case (num)
      12'h305: csr_index = 3'd1;
      12'h341: csr_index = 3'd2;
      12'h342: csr_index = 3'd3;
      12'h300: csr_index = 3'd4;
      12'hF11: csr_index = 3'd5;
      12'hF12: csr_index = 3'd6;
      default: csr_index = 3'd0;
    endcase
  endfunction

  state_t                state_r, state_s;
  logic [2:0]            op_r;
  logic [2:0]            idx_r;
  logic [DATA_WIDTH-1:0] rs1_r;
  logic                  rs1_zero_r;
  logic [RD_WIDTH-1:0]   rd_r;
  logic [31:0]           pc_r;
  logic [31:0]           target_r, target_s;
  logic                  illegal_r;
  logic                  accept_s;
  logic                  wen_s;
  logic [DATA_WIDTH-1:0] new_val_s;

  // Only mutable mapped CSRs (1-4) are written; RS/RC with rs1=x0 is a pure read.
  assign wen_s = (idx_r >= 3'd1) && (idx_r <= 3'd4) &&
                 !((op_r != OP_CSRRW) && rs1_zero_r);

  // Read-modify-write value for the latched CSR op
  always_comb begin
    case (op_r)
      OP_CSRRS: new_val_s = csr_rdata | rs1_r;
      OP_CSRRC: new_val_s = csr_rdata & ~rs1_r;
      default:  new_val_s = rs1_r;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_s     = state_r;
    target_s    = target_r;
    accept_s    = 1'b0;
    in_ready    = 1'b0;
    csr_addr    = 3'd0;
    csr_waddr   = 3'd0;
    csr_wdata   = {DATA_WIDTH{1'b0}};
    csr_wen     = 1'b0;
    csr_ecall   = 1'b0;
    csr_pc      = 32'd0;
    wb_valid    = 1'b0;
    wb_rd       = {RD_WIDTH{1'b0}};
    wb_data     = {DATA_WIDTH{1'b0}};
    redir_valid = 1'b0;
    redir_pc    = 32'd0;
    illegal     = illegal_r;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_s = 1'b1;
          case (in_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_MRET: state_s = EXEC;
            OP_ECALL: state_s = TRAP;
            default:  state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (op_r == OP_MRET) begin
          csr_addr = 3'd2;
          target_s = {csr_rdata[31:2], 2'b00};
          state_s  = REDIR;
        end else begin
          csr_addr  = idx_r;
          csr_waddr = idx_r;
          csr_wdata = new_val_s;
          csr_wen   = wen_s;
          wb_valid  = 1'b1;
          wb_rd     = rd_r;
          wb_data   = csr_rdata;
          state_s   = IDLE;
        end
      end
      TRAP: begin
        csr_ecall = 1'b1;
        csr_pc    = pc_r;
        csr_addr  = 3'd1;
        target_s  = {csr_rdata[31:2], 2'b00};
        state_s   = REDIR;
      end
      REDIR: begin
        redir_valid = 1'b1;
        redir_pc    = target_r;
        if (redir_ready) begin
          state_s = IDLE;
        end else begin
          state_s = REDIR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, latched instruction fields, redirect target and illegal pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      op_r       <= 3'd0;
      idx_r      <= 3'd0;
      rs1_r      <= {DATA_WIDTH{1'b0}};
      rs1_zero_r <= 1'b0;
      rd_r       <= {RD_WIDTH{1'b0}};
      pc_r       <= 32'd0;
      target_r   <= 32'd0;
      illegal_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      target_r  <= target_s;
      illegal_r <= accept_s && (in_op > OP_MRET);
      if (accept_s) begin
        op_r       <= in_op;
        idx_r      <= csr_index(in_csr);
        rs1_r      <= in_rs1_val;
        rs1_zero_r <= in_rs1_zero;
        rd_r       <= in_rd;
        pc_r       <= in_pc;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl with a behavioural 8-entry CSR file model
// and scoreboard queues for write-back and redirect expectations.
module tb_csr_trap_ctrl;
  localparam int DW = 32;
  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [2:0]    in_op;
  logic [11:0]   in_csr;
  logic [DW-1:0] in_rs1_val;
  logic          in_rs1_zero;
  logic [RW-1:0] in_rd;
  logic [31:0]   in_pc;
  logic [2:0]    csr_addr, csr_waddr;
  logic [DW-1:0] csr_rdata, csr_wdata;
  logic          csr_wen, csr_ecall;
  logic [31:0]   csr_pc;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          redir_valid, redir_ready;
  logic [31:0]   redir_pc;
  logic          illegal;

  logic [31:0] mem [8];
  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic [2:0]  waddr;
    logic [31:0] wdata;
  } wb_exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] csr;
    logic [31:0] rs1;
    logic        rz;
    logic [3:0]  rd;
    logic [31:0] wbd;
    logic        wen;
    logic [2:0]  waddr;
    logic [31:0] wdata;
  } op_vec_t;

  wb_exp_t     wb_q[$];
  logic [31:0] redir_q[$];

  always #5 clock = ~clock;

  csr_trap_ctrl #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_csr(in_csr),
    .in_rs1_val(in_rs1_val), .in_rs1_zero(in_rs1_zero), .in_rd(in_rd), .in_pc(in_pc),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_ecall(csr_ecall), .csr_pc(csr_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .illegal(illegal)
  );

  // CSR file model: combinational read, clocked write, ecall latches mepc/mcause
  assign csr_rdata = mem[csr_addr];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'd0;
      mem[5] <= 32'h0000_0600;
      mem[6] <= 32'd22050499;
    end else begin
      if (csr_wen) mem[csr_waddr] <= csr_wdata;
      if (csr_ecall) begin
        mem[2] <= csr_pc;
        mem[3] <= 32'd11;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] rs1,
                       input logic rz, input logic [3:0] rd, input logic [31:0] pc);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    ncmp++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL issue_ready got=%b want=1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_csr = csr; in_rs1_val = rs1;
    in_rs1_zero = rz; in_rd = rd; in_pc = pc;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_for(input bit want_redir, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!seen) begin
        if (want_redir ? (redir_valid === 1'b1) : (wb_valid === 1'b1)) seen = 1'b1;
        else @(negedge clock);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_csr = 12'd0; in_rs1_val = 32'd0;
    in_rs1_zero = 1'b0; in_rd = 4'd0; in_pc = 32'd0; redir_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ncmp++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    ncmp++;
    if ({csr_wen, csr_ecall, wb_valid, redir_valid, illegal} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_strobes got=%b want=00000", {csr_wen, csr_ecall, wb_valid, redir_valid, illegal});
    end
    ncmp++;
    if ({csr_addr, csr_waddr, csr_wdata, csr_pc, wb_rd, wb_data, redir_pc} !== '0) begin
      nerr++;
      $display("FAIL reset_data got addr=%0d waddr=%0d wdata=%h pc=%h rd=%0d wb=%h rpc=%h want all 0",
               csr_addr, csr_waddr, csr_wdata, csr_pc, wb_rd, wb_data, redir_pc);
    end
  endtask

  task automatic test_csrrw();
    wb_exp_t e;
    bit seen;
    wb_q.push_back('{4'd5, 32'd0, 1'b1, 3'd1, 32'h8000_0100});
    issue(3'd0, 12'h305, 32'h8000_0100, 1'b0, 4'd5, 32'd0);
    ncmp++;
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL rw_busy got=%b want=0", in_ready); end
    wait_for(1'b0, seen);
    e = wb_q.pop_front();
    ncmp++;
    if (!seen || wb_rd !== e.rd || wb_data !== e.data) begin
      nerr++;
      $display("FAIL rw_wb got v=%b rd=%0d data=%h want rd=%0d data=%h", wb_valid, wb_rd, wb_data, e.rd, e.data);
    end
    ncmp++;
    if (csr_wen !== e.wen || csr_waddr !== e.waddr || csr_wdata !== e.wdata) begin
      nerr++;
      $display("FAIL rw_write got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
               csr_wen, csr_waddr, csr_wdata, e.wen, e.waddr, e.wdata);
    end
    @(negedge clock);
    ncmp++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 || csr_wen !== 1'b0) begin
      nerr++;
      $display("FAIL rw_done got ready=%b wb=%b wen=%b want 1 0 0", in_ready, wb_valid, csr_wen);
    end
  endtask

  task automatic test_csr_ops();
    op_vec_t tbl [9];
    wb_exp_t e;
    bit seen;
    tbl[0] = '{3'd0, 12'h300, 32'h0000_1800, 1'b0, 4'd1, 32'h0000_0000, 1'b1, 3'd4, 32'h0000_1800};
    tbl[1] = '{3'd1, 12'h300, 32'h0000_0008, 1'b0, 4'd2, 32'h0000_1800, 1'b1, 3'd4, 32'h0000_1808};
    tbl[2] = '{3'd2, 12'h300, 32'h0000_0008, 1'b1, 4'd3, 32'h0000_1808, 1'b0, 3'd4, 32'h0000_0000};
    tbl[3] = '{3'd2, 12'h300, 32'h0000_0800, 1'b0, 4'd0, 32'h0000_1808, 1'b1, 3'd4, 32'h0000_1008};
    tbl[4] = '{3'd0, 12'hF12, 32'h0000_1234, 1'b0, 4'd4, 32'd22050499,  1'b0, 3'd6, 32'h0000_0000};
    tbl[5] = '{3'd0, 12'h7C0, 32'h0000_FFFF, 1'b0, 4'd6, 32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000};
    tbl[6] = '{3'd1, 12'h300, 32'h0000_0000, 1'b1, 4'd7, 32'h0000_1008, 1'b0, 3'd4, 32'h0000_0000};
    tbl[7] = '{3'd0, 12'hF11, 32'hFFFF_FFFF, 1'b0, 4'd8, 32'h0000_0600, 1'b0, 3'd5, 32'h0000_0000};
    tbl[8] = '{3'd1, 12'hF12, 32'h0000_0001, 1'b0, 4'd9, 32'd22050499,  1'b0, 3'd6, 32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      wb_q.push_back('{tbl[i].rd, tbl[i].wbd, tbl[i].wen, tbl[i].waddr, tbl[i].wdata});
      issue(tbl[i].op, tbl[i].csr, tbl[i].rs1, tbl[i].rz, tbl[i].rd, 32'd0);
      wait_for(1'b0, seen);
      e = wb_q.pop_front();
      ncmp++;
      if (!seen || wb_rd !== e.rd || wb_data !== e.data) begin
        nerr++;
        $display("FAIL ops_wb[%0d] got v=%b rd=%0d data=%h want rd=%0d data=%h",
                 i, wb_valid, wb_rd, wb_data, e.rd, e.data);
      end
      ncmp++;
      if (csr_wen !== e.wen || (e.wen && (csr_waddr !== e.waddr || csr_wdata !== e.wdata))) begin
        nerr++;
        $display("FAIL ops_write[%0d] got wen=%b waddr=%0d wdata=%h want wen=%b waddr=%0d wdata=%h",
                 i, csr_wen, csr_waddr, csr_wdata, e.wen, e.waddr, e.wdata);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_ecall();
    bit seen;
    logic [31:0] t;
    issue(3'd0, 12'h305, 32'h8000_0103, 1'b0, 4'd1, 32'd0);
    ncmp++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h8000_0100) begin
      nerr++; $display("FAIL ecall_setup got v=%b data=%h want 1 80000100", wb_valid, wb_data);
    end
    @(negedge clock);
    redir_ready = 1'b0;
    redir_q.push_back(32'h8000_0100);
    issue(3'd3, 12'h000, 32'd0, 1'b0, 4'd0, 32'h8000_0040);
    ncmp++;
    if (csr_ecall !== 1'b1 || csr_pc !== 32'h8000_0040) begin
      nerr++; $display("FAIL trap_pulse got ecall=%b pc=%h want 1 80000040", csr_ecall, csr_pc);
    end
    ncmp++;
    if ({wb_valid, csr_wen, redir_valid, in_ready} !== 4'b0) begin
      nerr++; $display("FAIL trap_quiet got %b want 0000", {wb_valid, csr_wen, redir_valid, in_ready});
    end
    @(negedge clock);
    wait_for(1'b1, seen);
    t = redir_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      ncmp++;
      if (!seen || redir_valid !== 1'b1 || redir_pc !== t || csr_ecall !== 1'b0) begin
        nerr++;
        $display("FAIL trap_hold[%0d] got v=%b pc=%h ecall=%b want 1 %h 0", i, redir_valid, redir_pc, csr_ecall, t);
      end
      @(negedge clock);
    end
    redir_ready = 1'b1;
    ncmp++;
    if (redir_valid !== 1'b1 || redir_pc !== t || in_ready !== 1'b0) begin
      nerr++; $display("FAIL trap_last got v=%b pc=%h ready=%b want 1 %h 0", redir_valid, redir_pc, in_ready, t);
    end
    @(negedge clock);
    ncmp++;
    if (redir_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL trap_release got v=%b ready=%b want 0 1", redir_valid, in_ready);
    end
  endtask

  task automatic test_mret();
    bit seen;
    logic [31:0] t;
    issue(3'd0, 12'h341, 32'h8000_0042, 1'b0, 4'd2, 32'd0);
    ncmp++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h8000_0040) begin
      nerr++; $display("FAIL mepc_latched got v=%b data=%h want 1 80000040", wb_valid, wb_data);
    end
    @(negedge clock);
    issue(3'd1, 12'h342, 32'd0, 1'b1, 4'd3, 32'd0);
    ncmp++;
    if (wb_data !== 32'd11 || csr_wen !== 1'b0) begin
      nerr++; $display("FAIL mcause_read got data=%h wen=%b want 0000000b 0", wb_data, csr_wen);
    end
    @(negedge clock);
    redir_q.push_back(32'h8000_0040);
    issue(3'd4, 12'h000, 32'd0, 1'b0, 4'd1, 32'd0);
    ncmp++;
    if ({wb_valid, csr_wen, csr_ecall, redir_valid} !== 4'b0) begin
      nerr++; $display("FAIL mret_exec got %b want 0000", {wb_valid, csr_wen, csr_ecall, redir_valid});
    end
    @(negedge clock);
    wait_for(1'b1, seen);
    t = redir_q.pop_front();
    ncmp++;
    if (!seen || redir_pc !== t || wb_valid !== 1'b0) begin
      nerr++; $display("FAIL mret_redir got v=%b pc=%h want 1 %h", redir_valid, redir_pc, t);
    end
    @(negedge clock);
    ncmp++;
    if (redir_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL mret_done got v=%b ready=%b want 0 1", redir_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] op;
    for (int k = 5; k < 8; k++) begin
      op = 3'(k);
      issue(op, 12'h305, 32'hDEAD_BEEF, 1'b0, 4'd1, 32'h8000_0000);
      ncmp++;
      if (illegal !== 1'b1 || in_ready !== 1'b1) begin
        nerr++; $display("FAIL illegal_pulse[%0d] got ill=%b ready=%b want 1 1", k, illegal, in_ready);
      end
      ncmp++;
      if ({csr_wen, csr_ecall, wb_valid, redir_valid} !== 4'b0) begin
        nerr++; $display("FAIL illegal_quiet[%0d] got %b want 0000", k, {csr_wen, csr_ecall, wb_valid, redir_valid});
      end
      @(negedge clock);
      ncmp++;
      if (illegal !== 1'b0) begin
        nerr++; $display("FAIL illegal_len[%0d] got %b want 0", k, illegal);
      end
    end
    issue(3'd1, 12'h305, 32'd0, 1'b1, 4'd1, 32'd0);
    ncmp++;
    if (wb_data !== 32'h8000_0103) begin
      nerr++; $display("FAIL illegal_nowrite got %h want 80000103", wb_data);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_redir();
    bit seen;
    bit bad;
    logic [31:0] t;
    redir_ready = 1'b0;
    redir_q.push_back(32'h8000_0100);
    issue(3'd3, 12'h000, 32'd0, 1'b0, 4'd0, 32'h8000_0080);
    @(negedge clock);
    wait_for(1'b1, seen);
    t = redir_q.pop_front();
    ncmp++;
    if (!seen || redir_pc !== t) begin
      nerr++; $display("FAIL rst_pre got v=%b pc=%h want 1 %h", redir_valid, redir_pc, t);
    end
    reset = 1'b1;
    @(negedge clock);
    ncmp++;
    if (redir_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_redir got v=%b ready=%b want 0 1", redir_valid, in_ready);
    end
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (csr_ecall !== 1'b0 || redir_valid !== 1'b0 || wb_valid !== 1'b0 || csr_wen !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    ncmp++;
    if (bad) begin nerr++; $display("FAIL rst_after got activity=1 want 0"); end
    redir_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_csrrw();
    test_csr_ops();
    test_ecall();
    test_mret();
    test_illegal();
    test_reset_redir();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
